// File: rtl/binarization_adaptive.sv
// Grey-to-monochrome binariser with a fixed or per-frame adaptive threshold.
// The adaptive threshold is the previous frame's mean luminance plus a signed offset.
module binarization_adaptive #(
   parameter int DATA_W      = 8,
   parameter int CNT_W       = 20,
   parameter int THRESH_INIT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pre_frame_vsync,
   input  logic              pre_frame_hsync,
   input  logic              pre_frame_de,
   input  logic [DATA_W-1:0] color,
   input  logic              cfg_mode,
   input  logic [DATA_W-1:0] cfg_thresh,
   input  logic [DATA_W:0]   cfg_offset,
   input  logic              cfg_invert,
   output logic              post_frame_vsync,
   output logic              post_frame_hsync,
   output logic              post_frame_de,
   output logic              monoc,
   output logic              monoc_rise,
   output logic              monoc_fall,
   output logic [DATA_W-1:0] cur_thresh,
   output logic              overrun
);
   // state | meaning
   // IDLE  | waiting for a frame boundary with adaptive mode and a non-empty snapshot
   // DIV   | restoring divide sum/cnt, one quotient bit per cycle
   // APPLY | add offset, clamp, then load cur_thresh or hold it as pending

   localparam int SUM_W  = DATA_W + CNT_W;
   localparam int DIV_CW = $clog2(SUM_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic signed [DATA_W+1:0] T_MAX = {2'b00, {DATA_W{1'b1}}};

   typedef enum logic [1:0] {IDLE, DIV, APPLY} state_t;

   state_t state, state_nxt;

   logic                     vs_d;
   logic                     vs_rise;
   logic                     invert_r;
   logic [DATA_W:0]          offset_r;
   logic [SUM_W-1:0]         sum;
   logic [CNT_W-1:0]         cnt;
   logic [SUM_W-1:0]         dvd;
   logic [CNT_W-1:0]         dvs;
   logic [CNT_W-1:0]         rem;
   logic [DIV_CW-1:0]        div_cnt;
   logic                     de_seen;
   logic                     pend_valid;
   logic [DATA_W-1:0]        pend_val;

   logic                     monoc_nxt;
   logic [CNT_W:0]           rem_sh;
   logic [CNT_W-1:0]         rem_sub;
   logic                     ge;
   logic signed [DATA_W+1:0] t_sum;
   logic [DATA_W-1:0]        t_clamp;
   logic                     pend_now;
   logic [DATA_W-1:0]        pend_value;
   logic                     div_load;
   logic                     apply_now;
   logic                     hold_now;
   logic                     ovr_nxt;

   assign vs_rise   = pre_frame_vsync & ~vs_d;
   assign monoc_nxt = pre_frame_de & ((color > cur_thresh) ^ invert_r);

   // After SUM_W shifts dvd holds the quotient; rem always stays below dvs.
   assign rem_sh  = {rem, dvd[SUM_W-1]};
   assign ge      = rem_sh >= {1'b0, dvs};
   assign rem_sub = rem_sh[CNT_W-1:0] - dvs;

   assign t_sum = $signed({2'b00, dvd[DATA_W-1:0]}) + $signed({offset_r[DATA_W], offset_r});

   always_comb begin
      t_clamp = t_sum[DATA_W-1:0];
      if (t_sum < 0)
         t_clamp = '0;
      else if (t_sum > T_MAX)
         t_clamp = '1;
   end

   // A result finishing in the same cycle as a frame boundary is treated as pending.
   assign pend_now   = pend_valid | (state == APPLY);
   assign pend_value = (state == APPLY) ? t_clamp : pend_val;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      div_load  = 1'b0;
      apply_now = 1'b0;
      hold_now  = 1'b0;
      ovr_nxt   = 1'b0;
      if (vs_rise) begin
         ovr_nxt   = (state == DIV);
         state_nxt = IDLE;
         if (cfg_mode && !pend_now && (cnt != '0)) begin
            state_nxt = DIV;
            div_load  = 1'b1;
         end
      end else begin
         case (state)
            DIV:
               if (div_cnt == '0)
                  state_nxt = APPLY;
            APPLY: begin
               state_nxt = IDLE;
               if (de_seen | pre_frame_de) begin
                  hold_now = 1'b1;
                  ovr_nxt  = 1'b1;
               end else begin
                  apply_now = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_d             <= 1'b0;
         post_frame_vsync <= 1'b0;
         post_frame_hsync <= 1'b0;
         post_frame_de    <= 1'b0;
         monoc            <= 1'b0;
         monoc_rise       <= 1'b0;
         monoc_fall       <= 1'b0;
         overrun          <= 1'b0;
         cur_thresh       <= DATA_W'(THRESH_INIT);
         invert_r         <= 1'b0;
         offset_r         <= '0;
         sum              <= '0;
         cnt              <= '0;
         dvd              <= '0;
         dvs              <= '0;
         rem              <= '0;
         div_cnt          <= '0;
         de_seen          <= 1'b0;
         pend_valid       <= 1'b0;
         pend_val         <= '0;
      end else begin
         vs_d             <= pre_frame_vsync;
         post_frame_vsync <= pre_frame_vsync;
         post_frame_hsync <= pre_frame_hsync;
         post_frame_de    <= pre_frame_de;
         monoc            <= monoc_nxt;
         monoc_rise       <= pre_frame_de & post_frame_de & monoc_nxt & ~monoc;
         monoc_fall       <= pre_frame_de & post_frame_de & ~monoc_nxt & monoc;
         overrun          <= ovr_nxt;

         if (vs_rise) begin
            invert_r   <= cfg_invert;
            offset_r   <= cfg_offset;
            sum        <= pre_frame_de ? {{CNT_W{1'b0}}, color} : '0;
            cnt        <= {{(CNT_W-1){1'b0}}, pre_frame_de};
            de_seen    <= pre_frame_de;
            pend_valid <= 1'b0;
            if (!cfg_mode)
               cur_thresh <= cfg_thresh;
            else if (pend_now)
               cur_thresh <= pend_value;
         end else begin
            if (pre_frame_de && (cnt != CNT_MAX)) begin
               sum <= sum + {{CNT_W{1'b0}}, color};
               cnt <= cnt + CNT_W'(1);
            end
            de_seen <= de_seen | pre_frame_de;
            if (apply_now)
               cur_thresh <= t_clamp;
            if (hold_now) begin
               pend_valid <= 1'b1;
               pend_val   <= t_clamp;
            end
         end

         if (div_load) begin
            dvd     <= sum;
            dvs     <= cnt;
            rem     <= '0;
            div_cnt <= DIV_CW'(SUM_W - 1);
         end else if (state == DIV) begin
            dvd     <= {dvd[SUM_W-2:0], ge};
            rem     <= ge ? rem_sub : rem_sh[CNT_W-1:0];
            div_cnt <= div_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_binarization_adaptive.sv
// Scoreboard bench for binarization_adaptive: per-pixel expectations are queued
// at drive time and compared one clock later; thresholds are checked at frame points.
module tb_binarization_adaptive;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pre_frame_vsync, pre_frame_hsync, pre_frame_de;
   logic [7:0] color;
   logic       cfg_mode;
   logic [7:0] cfg_thresh;
   logic [8:0] cfg_offset;
   logic       cfg_invert;
   logic       post_frame_vsync, post_frame_hsync, post_frame_de;
   logic       monoc, monoc_rise, monoc_fall;
   logic [7:0] cur_thresh;
   logic       overrun;

   binarization_adaptive #(.DATA_W(8), .CNT_W(20), .THRESH_INIT(64)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .pre_frame_vsync  (pre_frame_vsync),
      .pre_frame_hsync  (pre_frame_hsync),
      .pre_frame_de     (pre_frame_de),
      .color            (color),
      .cfg_mode         (cfg_mode),
      .cfg_thresh       (cfg_thresh),
      .cfg_offset       (cfg_offset),
      .cfg_invert       (cfg_invert),
      .post_frame_vsync (post_frame_vsync),
      .post_frame_hsync (post_frame_hsync),
      .post_frame_de    (post_frame_de),
      .monoc            (monoc),
      .monoc_rise       (monoc_rise),
      .monoc_fall       (monoc_fall),
      .cur_thresh       (cur_thresh),
      .overrun          (overrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic vs;
      logic hs;
      logic de;
      logic mon;
      logic rise;
      logic fall;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;

   int n_total = 0;
   int n_bad   = 0;
   int ovr_cnt = 0;
   int rise_cnt = 0;
   int fall_cnt = 0;
   int r0, f0, o0;

   logic [7:0] mdl_thr;
   logic       mdl_inv;
   logic       m_prev_de, m_prev_mon, m_prev_vs;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input logic vs, input logic hs, input logic de, input logic [7:0] pix);
      exp_t e;
      @(negedge clk);
      pre_frame_vsync = vs;
      pre_frame_hsync = hs;
      pre_frame_de    = de;
      color           = pix;
      e.vs   = vs;
      e.hs   = hs;
      e.de   = de;
      e.mon  = de & ((pix > mdl_thr) ^ mdl_inv);
      e.rise = de & m_prev_de & e.mon & ~m_prev_mon;
      e.fall = de & m_prev_de & ~e.mon & m_prev_mon;
      q.push_back(e);
      m_prev_de  = de;
      m_prev_mon = e.mon;
      if (vs && !m_prev_vs) begin
         mdl_inv = cfg_invert;
         if (!cfg_mode)
            mdl_thr = cfg_thresh;
      end
      m_prev_vs = vs;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++)
         tick(1'b0, 1'b0, 1'b0, 8'd0);
   endtask

   task automatic vsync();
      tick(1'b1, 1'b0, 1'b0, 8'd0);
      tick(1'b1, 1'b0, 1'b0, 8'd0);
      tick(1'b0, 1'b0, 1'b0, 8'd0);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (overrun)    ovr_cnt++;
         if (monoc_rise) rise_cnt++;
         if (monoc_fall) fall_cnt++;
         if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("outs", {post_frame_vsync, post_frame_hsync, post_frame_de,
                         monoc, monoc_rise, monoc_fall}, mon_e);
         end
      end
   end

   initial begin
      pre_frame_vsync = 1'b0;
      pre_frame_hsync = 1'b0;
      pre_frame_de    = 1'b0;
      color           = 8'd0;
      cfg_mode        = 1'b0;
      cfg_thresh      = 8'd64;
      cfg_offset      = 9'd0;
      cfg_invert      = 1'b0;
      mdl_thr = 8'd64;
      mdl_inv = 1'b0;
      m_prev_de = 1'b0;
      m_prev_mon = 1'b0;
      m_prev_vs = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_thr", cur_thresh, 64);
      chk("rst_outs", {post_frame_vsync, post_frame_hsync, post_frame_de, monoc,
                       monoc_rise, monoc_fall, overrun}, 0);

      // fixed threshold 64, ramp
      vsync();
      idle(3);
      r0 = rise_cnt; f0 = fall_cnt;
      for (int i = 0; i < 256; i++) tick(1'b0, 1'b1, 1'b1, i[7:0]);
      idle(3);
      chk("ramp_rise", rise_cnt - r0, 1);
      chk("ramp_fall", fall_cnt - f0, 0);
      chk("fix_thr", cur_thresh, 64);

      // inverted, with a mid-frame toggle that must not take effect
      cfg_invert = 1'b1;
      vsync();
      idle(3);
      r0 = rise_cnt; f0 = fall_cnt;
      for (int i = 0; i < 256; i++) begin
         if (i == 100) cfg_invert = 1'b0;
         tick(1'b0, 1'b1, 1'b1, i[7:0]);
      end
      idle(3);
      chk("inv_rise", rise_cnt - r0, 0);
      chk("inv_fall", fall_cnt - f0, 1);

      // adaptive: mean 100, offset -10
      vsync();
      idle(2);
      for (int i = 0; i < 100; i++) tick(1'b0, 1'b1, 1'b1, 8'd100);
      idle(3);
      cfg_mode = 1'b1;
      cfg_offset = 9'h1F6;
      o0 = ovr_cnt;
      vsync();
      idle(40);
      chk("adp_thr", cur_thresh, 90);
      chk("adp_ovr", ovr_cnt - o0, 0);
      mdl_thr = 8'd90;

      // mean 250 + 20 clamps high
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b1, (i % 2 == 0) ? 8'd245 : 8'd255);
      idle(3);
      cfg_offset = 9'd20;
      vsync();
      idle(40);
      chk("clamp_hi", cur_thresh, 255);
      mdl_thr = 8'd255;

      // mean 5 - 20 clamps low
      tick(1'b0, 1'b1, 1'b1, 8'd4);
      tick(1'b0, 1'b1, 1'b1, 8'd6);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 8'd5);
      idle(3);
      cfg_offset = 9'h1EC;
      vsync();
      idle(40);
      chk("clamp_lo", cur_thresh, 0);
      mdl_thr = 8'd0;

      // overrun: mean 40, de arrives 3 cycles after the frame boundary
      tick(1'b0, 1'b1, 1'b1, 8'd0);
      tick(1'b0, 1'b1, 1'b1, 8'd80);
      tick(1'b0, 1'b1, 1'b1, 8'd40);
      tick(1'b0, 1'b1, 1'b1, 8'd40);
      idle(3);
      cfg_offset = 9'd0;
      o0 = ovr_cnt;
      vsync();
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 8'd200);
      idle(40);
      chk("ovr_pulse", ovr_cnt - o0, 1);
      chk("ovr_hold", cur_thresh, 0);
      vsync();
      idle(3);
      chk("pend_thr", cur_thresh, 40);
      mdl_thr = 8'd40;
      idle(37);
      chk("pend_ovr", ovr_cnt - o0, 1);
      chk("pend_keep", cur_thresh, 40);
      vsync();
      idle(40);
      chk("empty_thr", cur_thresh, 40);

      // edge strobes with a de gap
      cfg_mode = 1'b0;
      cfg_thresh = 8'd100;
      vsync();
      idle(2);
      r0 = rise_cnt; f0 = fall_cnt;
      tick(1'b0, 1'b1, 1'b1, 8'd0);
      tick(1'b0, 1'b1, 1'b1, 8'd200);
      tick(1'b0, 1'b1, 1'b1, 8'd0);
      tick(1'b0, 1'b1, 1'b1, 8'd200);
      tick(1'b0, 1'b1, 1'b0, 8'd0);
      tick(1'b0, 1'b1, 1'b1, 8'd200);
      idle(3);
      chk("edge_rise", rise_cnt - r0, 2);
      chk("edge_fall", fall_cnt - f0, 1);

      // reset during DIV
      cfg_mode = 1'b1;
      cfg_offset = 9'd0;
      vsync();
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b1, 8'd200);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_thr", cur_thresh, 64);
      chk("arst_outs", {post_frame_vsync, post_frame_hsync, post_frame_de, monoc,
                        monoc_rise, monoc_fall, overrun}, 0);
      q.delete();
      pre_frame_vsync = 1'b0;
      pre_frame_hsync = 1'b0;
      pre_frame_de    = 1'b0;
      color           = 8'd0;
      m_prev_de = 1'b0;
      m_prev_mon = 1'b0;
      m_prev_vs = 1'b0;
      mdl_thr = 8'd64;
      mdl_inv = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      o0 = ovr_cnt;
      idle(40);
      chk("post_rst_thr", cur_thresh, 64);
      chk("post_rst_ovr", ovr_cnt - o0, 0);
      vsync();
      idle(40);
      chk("post_rst_empty", cur_thresh, 64);
      tick(1'b0, 1'b1, 1'b1, 8'd64);
      tick(1'b0, 1'b1, 1'b1, 8'd65);
      idle(3);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/binarization_adaptive.md
Name: binarization_adaptive

Overview:
Parametrised successor to the fixed-threshold binariser in the vip pipeline. Converts a DATA_W-bit grey stream to 1-bit monochrome. The threshold is either a runtime value or adapted per frame from the previous frame's mean luminance plus a signed offset. Outputs rise/fall edge strobes per line for the downstream digit segmentation blocks.

Parameters:
DATA_W, 8, pixel width in bits.
CNT_W, 20, pixel-counter width; at most 2^CNT_W-1 pixels per frame are accumulated.
THRESH_INIT, 64, active threshold after reset.

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
pre_frame_vsync  in  1  vsync, active high; rising edge = frame boundary
pre_frame_hsync  in  1  hsync
pre_frame_de  in  1  data enable
color  in  DATA_W  grey pixel
cfg_mode  in  1  0 = fixed (cfg_thresh), 1 = adaptive (mean + cfg_offset)
cfg_thresh  in  DATA_W  fixed threshold
cfg_offset  in  DATA_W+1  signed two's-complement offset for adaptive mode
cfg_invert  in  1  1 = invert monoc polarity
post_frame_vsync  out  1  vsync delayed 1 cycle
post_frame_hsync  out  1  hsync delayed 1 cycle
post_frame_de  out  1  de delayed 1 cycle
monoc  out  1  1 = white (color > threshold, XOR cfg_invert); 0 when post_frame_de low
monoc_rise  out  1  0->1 transition inside a line
monoc_fall  out  1  1->0 transition inside a line
cur_thresh  out  DATA_W  active threshold
overrun  out  1  one-cycle pulse: adaptive result arrived after the frame had started

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All outputs are 0 in reset, except cur_thresh, which resets to THRESH_INIT. The divider/state machine goes to IDLE, and all accumulators clear.
- Latency: exactly 1 cycle from color/sync inputs to monoc/post_* outputs.
- monoc = (color > cur_thresh) XOR cfg_invert, registered, gated by pre_frame_de. Compare is unsigned.
- Edges: monoc_rise/monoc_fall are valid in the same cycle as monoc. They assert only when post_frame_de is high in both the current and previous cycle and monoc differs from its previous value. The first pixel of each line never strobes, and neither does any pixel after a de gap.
- Config sampling: cfg_mode, cfg_thresh, cfg_offset and cfg_invert are sampled only at the vsync rising edge (vs_rise). Mid-frame changes have no effect until the next frame.
- Fixed mode: cur_thresh <= cfg_thresh at vs_rise.
- Accumulator: on each de cycle, sum += color and cnt += 1. Width of sum is DATA_W+CNT_W.
  - When cnt = 2^CNT_W-1, further pixels are ignored; sum and cnt freeze.
  - At vs_rise, sum/cnt are snapshotted into the divider and cleared in the same cycle. The current-cycle pixel, if any, counts toward the new frame.
- State machine (adaptive path):
  - IDLE: on vs_rise with sampled cfg_mode=1 and snapshot cnt!=0, go to DIV. If cnt==0, stay in IDLE and cur_thresh is unchanged.
  - DIV: restoring divider, one quotient bit per cycle, DATA_W+CNT_W cycles. mean = floor(sum/cnt), which always fits in DATA_W.
  - APPLY (1 cycle): t = mean + offset, computed signed in DATA_W+2 bits and clamped to [0, 2^DATA_W-1].
    - If no pre_frame_de has been seen since the vs_rise that started this DIV, cur_thresh <= t, then go to IDLE.
    - Otherwise hold t pending, pulse overrun, and go to IDLE. cur_thresh <= pending at the next vs_rise, which takes priority over starting a new DIV in that same cycle. In that cycle the new snapshot is discarded and treated as cnt==0.
  - vs_rise during DIV: abort, discard the result, pulse overrun, and restart DIV with the new snapshot (IDLE rules apply).
- Mode switch 1->0 at vs_rise: fixed mode wins and any pending/in-flight adaptive result is discarded. Switch 0->1: cur_thresh keeps its last value until the first adaptive APPLY.
- Reset mid-DIV: everything is cleared; the next frame uses THRESH_INIT.

Test Plan:
- Fixed mode, cfg_thresh=64, line ramp 0..255 -> monoc=0 for color<=64 and 1 for 65..255. monoc_rise exactly once at the pixel with color 65 (1 cycle after input); no fall strobe.
- cfg_invert=1 sampled at vs_rise, same ramp -> monoc=1 for <=64. A cfg_invert toggle mid-frame has no effect until the next vsync.
- Adaptive, offset=-10: frame of 100 uniform pixels of value 100, long vblank -> cur_thresh=90 before next frame's first de; no overrun.
- Clamp cases: frame mean 250 with offset +20 -> cur_thresh=255. Mean 5 with offset -20 -> cur_thresh=0.
- Overrun: frame with de cycles followed by de 3 cycles after vs_rise (less than DATA_W+CNT_W) -> overrun pulses once; cur_thresh updates at the following vs_rise. An empty frame (cnt=0) leaves cur_thresh unchanged.
- Edges and reset: line pattern 0,200,0,200 with de gap then 200 -> rise/fall alternate, and no strobe after the gap. rst_n low during DIV -> cur_thresh=64 and all outputs 0 immediately (async).
